// File: rtl/idiv_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// registered quotient/remainder with a one-cycle done pulse.
module idiv_restoring #(
    parameter int SIZE = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            iStart,
    input  logic [SIZE-1:0] iDividend,
    input  logic [SIZE-1:0] iDivisor,
    output logic [SIZE-1:0] oQuotient,
    output logic [SIZE-1:0] oRemainder,
    output logic            oBusy,
    output logic            oDone,
    output logic            oDivByZero
);

    localparam int CW = $clog2(SIZE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [SIZE:0]   r_rem;
    logic [SIZE-1:0] r_quo;
    logic [SIZE-1:0] r_div;
    logic            r_dz;
    logic [SIZE-1:0] r_q_out;
    logic [SIZE-1:0] r_r_out;
    logic            r_busy;
    logic            r_done;
    logic            r_dz_out;

    logic [SIZE:0]   w_shift_rem;
    logic [SIZE:0]   w_trial;
    logic            w_qbit;
    logic [SIZE:0]   w_rem_next;
    logic [SIZE-1:0] w_quo_next;
    logic            w_last;

    // One restoring step. The partial remainder never exceeds SIZE bits
    // between steps, so only its low bits take part in the shift.
    always_comb begin
        w_shift_rem = {r_rem[SIZE-1:0], r_quo[SIZE-1]};
        w_trial     = w_shift_rem - {1'b0, r_div};
        w_qbit      = ~w_trial[SIZE];
        if (w_qbit) begin
            w_rem_next = w_trial;
        end else begin
            w_rem_next = w_shift_rem;
        end
        w_quo_next = {r_quo[SIZE-2:0], w_qbit};
        w_last     = (r_cnt == CW'(SIZE - 1));
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_dz     <= 1'b0;
            r_q_out  <= '0;
            r_r_out  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (iStart) begin
                        r_quo   <= iDividend;
                        r_div   <= iDivisor;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_dz    <= (iDivisor == {SIZE{1'b0}});
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // A zero divisor skips the steps; the dividend is still in r_quo.
                    if (r_dz) begin
                        r_q_out  <= {SIZE{1'b1}};
                        r_r_out  <= r_quo;
                        r_dz_out <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_q_out  <= w_quo_next;
                            r_r_out  <= w_rem_next[SIZE-1:0];
                            r_dz_out <= 1'b0;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign oQuotient  = r_q_out;
    assign oRemainder = r_r_out;
    assign oBusy      = r_busy;
    assign oDone      = r_done;
    assign oDivByZero = r_dz_out;

endmodule
